// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative cache controller: byte-wide CPU port, line-wide memory port,
// true-LRU replacement and run-time write-back / write-through selection.
module assoc_cache_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int BLOCK_BYTES = 16,
    parameter int SETS        = 2,
    parameter int WAYS        = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_mode,
    input  logic                     cpu_req,
    input  logic                     cpu_rw,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [7:0]               cpu_wdata,
    output logic [7:0]               cpu_rdata,
    output logic                     cpu_ready,
    output logic                     cpu_hit,
    output logic                     mem_req,
    output logic                     mem_rw,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [BLOCK_BYTES*8-1:0] mem_wdata,
    input  logic [BLOCK_BYTES*8-1:0] mem_rdata,
    input  logic                     mem_ready
);
    localparam int OFF_W  = $clog2(BLOCK_BYTES);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int LINE_W = BLOCK_BYTES * 8;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AGE_W  = WAY_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WRITEBACK, S_REFILL, S_WTHRU, S_RESPOND
    } state_t;

    state_t            state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              hit_q, hit_d;
    logic [WAY_W-1:0]  way_q, way_d;
    logic              fresh_q, fresh_d;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [WAYS-1:0]   dirty_q [SETS];
    logic [WAYS-1:0]   dirty_d [SETS];
    logic [AGE_W-1:0]  age_q   [SETS][WAYS];
    logic [AGE_W-1:0]  age_d   [SETS][WAYS];

    logic [LINE_W-1:0] data_q  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];

    logic              data_we, tag_we;
    logic [WAY_W-1:0]  data_way;
    logic [LINE_W-1:0] data_line;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic [LINE_W-1:0] cur_line;

    logic              lk_hit;
    logic [WAY_W-1:0]  lk_way;
    logic              vic_found;
    logic [WAY_W-1:0]  vic_way;
    logic [AGE_W-1:0]  max_age;
    logic [AGE_W-1:0]  acc_age;

    assign req_tag  = addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx  = addr_q[OFF_W +: IDX_W];
    assign req_off  = addr_q[OFF_W-1:0];
    assign cur_line = data_q[req_idx][way_q];

    // Byte k of a line sits at the big-endian position (byte 0 in the MSBs).
    function automatic logic [LINE_W-1:0] merge_byte(input logic [LINE_W-1:0] line,
                                                     input logic [OFF_W-1:0]  off,
                                                     input logic [7:0]        b);
        int sh;
        sh = 8 * (BLOCK_BYTES - 1 - int'(off));
        return (line & ~({{(LINE_W-8){1'b0}}, 8'hFF} << sh)) |
               ({{(LINE_W-8){1'b0}}, b} << sh);
    endfunction

    function automatic logic [7:0] pick_byte(input logic [LINE_W-1:0] line,
                                             input logic [OFF_W-1:0]  off);
        logic [LINE_W-1:0] tmp;
        tmp = line >> (8 * (BLOCK_BYTES - 1 - int'(off)));
        return tmp[7:0];
    endfunction

    always_comb begin
        lk_hit    = 1'b0;
        lk_way    = '0;
        vic_found = 1'b0;
        vic_way   = '0;
        max_age   = age_q[req_idx][0];
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!lk_hit && valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (!vic_found && !valid_q[req_idx][w]) begin
                vic_found = 1'b1;
                vic_way   = WAY_W'(w);
            end
        end
        if (!vic_found) begin
            for (int unsigned w = 1; w < WAYS; w++) begin
                if (age_q[req_idx][w] > max_age) begin
                    max_age = age_q[req_idx][w];
                    vic_way = WAY_W'(w);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        hit_d     = hit_q;
        way_d     = way_q;
        fresh_d   = fresh_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        age_d     = age_q;
        data_we   = 1'b0;
        tag_we    = 1'b0;
        data_way  = way_q;
        data_line = cur_line;
        acc_age   = '0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    rw_d    = cpu_rw;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d = lk_hit;
                if (lk_hit) begin
                    way_d   = lk_way;
                    fresh_d = 1'b0;
                    state_d = S_RESPOND;
                    if (rw_q) begin
                        data_we   = 1'b1;
                        data_way  = lk_way;
                        data_line = merge_byte(data_q[req_idx][lk_way], req_off, wdata_q);
                        if (wb_mode) dirty_d[req_idx][lk_way] = 1'b1;
                        else         state_d = S_WTHRU;
                    end
                end else begin
                    way_d   = vic_way;
                    fresh_d = vic_found;
                    if (!vic_found && dirty_q[req_idx][vic_way]) state_d = S_WRITEBACK;
                    else                                          state_d = S_REFILL;
                end
            end
            S_WRITEBACK: begin
                if (mem_ready) state_d = S_REFILL;
            end
            S_REFILL: begin
                if (mem_ready) begin
                    data_we   = 1'b1;
                    tag_we    = 1'b1;
                    data_line = rw_q ? merge_byte(mem_rdata, req_off, wdata_q) : mem_rdata;
                    valid_d[req_idx][way_q] = 1'b1;
                    dirty_d[req_idx][way_q] = rw_q && wb_mode;
                    state_d = (rw_q && !wb_mode) ? S_WTHRU : S_RESPOND;
                end
            end
            S_WTHRU: begin
                if (mem_ready) state_d = S_RESPOND;
            end
            S_RESPOND: begin
                // A way filled from invalid is treated as oldest so ages stay a permutation
                // once the set is full, even though reset clears every age to zero.
                if (WAYS > 1) begin
                    acc_age = fresh_q ? '1 : age_q[req_idx][way_q];
                    for (int unsigned w = 0; w < WAYS; w++) begin
                        if (WAY_W'(w) == way_q)
                            age_d[req_idx][w] = '0;
                        else if (age_q[req_idx][w] < acc_age)
                            age_d[req_idx][w] = age_q[req_idx][w] + 1'b1;
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = (state_q == S_RESPOND);
        cpu_hit   = cpu_ready && hit_q;
        cpu_rdata = '0;
        if (cpu_ready) cpu_rdata = rw_q ? wdata_q : pick_byte(cur_line, req_off);
        mem_req   = 1'b0;
        mem_rw    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_WRITEBACK: begin
                mem_req   = 1'b1;
                mem_rw    = 1'b1;
                mem_addr  = {tag_q[req_idx][way_q], req_idx, {OFF_W{1'b0}}};
                mem_wdata = cur_line;
            end
            S_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
            end
            S_WTHRU: begin
                mem_req   = 1'b1;
                mem_rw    = 1'b1;
                mem_addr  = {req_tag, req_idx, {OFF_W{1'b0}}};
                mem_wdata = cur_line;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            fresh_q <= 1'b0;
            for (int unsigned s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) age_q[s][w] <= '0;
            end
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hit_q   <= hit_d;
            way_q   <= way_d;
            fresh_q <= fresh_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            age_q   <= age_d;
        end
    end

    always_ff @(posedge clk) begin
        if (data_we) data_q[req_idx][data_way] <= data_line;
        if (tag_we)  tag_q[req_idx][data_way]  <= req_tag;
    end

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// Directed bench for assoc_cache_ctrl: default 2-set/2-way instance plus a 4-set/4-way
// instance for LRU replacement order.
module tb_assoc_cache_ctrl;
    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, wb_mode;
    logic         cpu_req, cpu_rw, cpu_ready, cpu_hit;
    logic [9:0]   cpu_addr;
    logic [7:0]   cpu_wdata, cpu_rdata;
    logic         mem_req, mem_rw, mem_ready;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    logic         b_cpu_req, b_cpu_rw, b_cpu_ready, b_cpu_hit;
    logic [9:0]   b_cpu_addr;
    logic [7:0]   b_cpu_wdata, b_cpu_rdata;
    logic         b_mem_req, b_mem_rw, b_mem_ready;
    logic [9:0]   b_mem_addr;
    logic [127:0] b_mem_wdata, b_mem_rdata;

    assoc_cache_ctrl #(.ADDR_W(10), .BLOCK_BYTES(16), .SETS(2), .WAYS(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .wb_mode(wb_mode),
        .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
        .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    assoc_cache_ctrl #(.ADDR_W(10), .BLOCK_BYTES(16), .SETS(4), .WAYS(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wb_mode(wb_mode),
        .cpu_req(b_cpu_req), .cpu_rw(b_cpu_rw), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_rdata(b_cpu_rdata), .cpu_ready(b_cpu_ready), .cpu_hit(b_cpu_hit),
        .mem_req(b_mem_req), .mem_rw(b_mem_rw), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .mem_ready(b_mem_ready)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int           lat, n_tx, stable_err;
    logic         r_done, r_hit;
    logic [7:0]   r_data;
    logic [9:0]   tx_addr [4];
    logic         tx_rw   [4];
    logic [127:0] tx_data [4];

    // One CPU access on instance A; memory answers after `stall` waiting cycles.
    task automatic access_a(input string tag, input logic rw, input logic [9:0] addr,
                            input logic [7:0] wd, input logic [127:0] rline, input int stall);
        int         edges;
        int         wait_ct;
        logic       in_txn;
        logic [9:0] hold_addr;
        logic       hold_rw;
        n_tx = 0; stable_err = 0; r_done = 1'b0; r_hit = 1'b0; r_data = '0;
        in_txn = 1'b0; wait_ct = 0; lat = 0; hold_addr = '0; hold_rw = 1'b0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        cpu_req = 1'b0; cpu_rw = ~rw; cpu_addr = ~addr; cpu_wdata = ~wd;
        while (!r_done && edges < 200) begin
            if (cpu_ready) begin
                r_done = 1'b1; r_hit = cpu_hit; r_data = cpu_rdata; lat = edges;
            end else begin
                if (mem_req) begin
                    if (!in_txn) begin
                        in_txn = 1'b1; wait_ct = 0;
                        if (n_tx < 4) begin
                            tx_addr[n_tx] = mem_addr; tx_rw[n_tx] = mem_rw; tx_data[n_tx] = mem_wdata;
                        end
                        n_tx++;
                        hold_addr = mem_addr; hold_rw = mem_rw;
                    end else if (mem_addr !== hold_addr || mem_rw !== hold_rw) begin
                        stable_err++;
                    end
                    if (wait_ct == stall) begin
                        mem_ready = 1'b1; mem_rdata = rline;
                    end else begin
                        wait_ct++;
                    end
                end
                @(posedge clk);
                edges++;
                @(negedge clk);
                if (mem_ready) begin
                    mem_ready = 1'b0; in_txn = 1'b0;
                end
            end
        end
        check_eq({tag, "_done"}, r_done, 1);
        @(negedge clk);
        check_eq({tag, "_pulse"}, {cpu_ready, mem_req}, 2'b00);
    endtask

    task automatic access_b(input logic [9:0] addr, output logic hit, output logic [9:0] rf_addr,
                            output logic done);
        int edges;
        done = 1'b0; hit = 1'b0; rf_addr = '0;
        @(negedge clk);
        b_cpu_req = 1'b1; b_cpu_rw = 1'b0; b_cpu_addr = addr;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        b_cpu_req = 1'b0;
        while (!done && edges < 100) begin
            if (b_cpu_ready) begin
                done = 1'b1; hit = b_cpu_hit;
            end else begin
                if (b_mem_req) begin
                    b_mem_ready = 1'b1; rf_addr = b_mem_addr;
                end
                @(posedge clk);
                edges++;
                @(negedge clk);
                b_mem_ready = 1'b0;
            end
        end
    endtask

    localparam logic [127:0] PAT = 128'h00112233_44556677_8899AABB_CCDDEEFF;

    logic [9:0] b_addr [11] = '{10'h040, 10'h080, 10'h0C0, 10'h100, 10'h040, 10'h140,
                                10'h040, 10'h0C0, 10'h100, 10'h140, 10'h080};
    logic       b_exp  [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       bh, bd;
        logic [9:0] bra;
        rst_n = 1'b0; wb_mode = 1'b1;
        cpu_req = 1'b0; cpu_rw = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        b_cpu_req = 1'b0; b_cpu_rw = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
        b_mem_ready = 1'b0; b_mem_rdata = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_cpu", {cpu_ready, cpu_hit, cpu_rdata}, 10'h0);
        check_eq("reset_mem", {mem_req, mem_rw, mem_addr}, 12'h0);
        check_eq("reset_wdata", mem_wdata, 128'h0);
        rst_n = 1'b1;

        access_a("wmiss", 1'b1, 10'h101, 8'hFF, 128'h0, 0);
        check_eq("wmiss_hit", r_hit, 0);
        check_eq("wmiss_ntx", n_tx, 1);
        check_eq("wmiss_tx", {tx_rw[0], tx_addr[0]}, {1'b0, 10'h100});
        check_eq("wmiss_lat", lat, 3);
        check_eq("wmiss_rdata", r_data, 8'hFF);

        access_a("rhit", 1'b0, 10'h101, 8'h00, 128'h0, 0);
        check_eq("rhit_hit", r_hit, 1);
        check_eq("rhit_rdata", r_data, 8'hFF);
        check_eq("rhit_lat", lat, 2);
        check_eq("rhit_ntx", n_tx, 0);

        access_a("r202", 1'b0, 10'h202, 8'h00, PAT, 0);
        check_eq("r202_hit", r_hit, 0);
        check_eq("r202_tx", {n_tx[2:0], tx_addr[0]}, {3'd1, 10'h200});
        check_eq("r202_rdata", r_data, 8'h22);

        access_a("r104", 1'b0, 10'h104, 8'h00, PAT, 0);
        check_eq("r104_hit", {r_hit, r_data}, {1'b1, 8'h00});

        access_a("r088", 1'b0, 10'h088, 8'h00, PAT, 0);
        check_eq("r088_hit", r_hit, 0);
        check_eq("r088_tx", {n_tx[2:0], tx_rw[0], tx_addr[0]}, {3'd1, 1'b0, 10'h080});
        check_eq("r088_rdata", r_data, 8'h88);

        access_a("r300", 1'b0, 10'h300, 8'h00, 128'h0, 0);
        check_eq("r300_ntx", n_tx, 2);
        check_eq("r300_wb", {tx_rw[0], tx_addr[0]}, {1'b1, 10'h100});
        check_eq("r300_wbdata", tx_data[0], 128'h00FF0000_00000000_00000000_00000000);
        check_eq("r300_rf", {tx_rw[1], tx_addr[1]}, {1'b0, 10'h300});
        check_eq("r300_lat", lat, 4);

        access_a("stall", 1'b0, 10'h210, 8'h00, 128'h0, 5);
        check_eq("stall_tx", {n_tx[2:0], tx_addr[0]}, {3'd1, 10'h210});
        check_eq("stall_stable", stable_err, 0);
        check_eq("stall_lat", lat, 8);

        wb_mode = 1'b0;
        access_a("wt_miss", 1'b1, 10'h117, 8'hFE, 128'h0, 0);
        check_eq("wt_miss_ntx", n_tx, 2);
        check_eq("wt_miss_rf", {tx_rw[0], tx_addr[0]}, {1'b0, 10'h110});
        check_eq("wt_miss_wt", {tx_rw[1], tx_addr[1]}, {1'b1, 10'h110});
        check_eq("wt_miss_data", tx_data[1], 128'h00000000_000000FE_00000000_00000000);
        check_eq("wt_miss_lat", lat, 4);

        access_a("wt_hit", 1'b1, 10'h117, 8'h11, 128'h0, 0);
        check_eq("wt_hit_hit", r_hit, 1);
        check_eq("wt_hit_ntx", n_tx, 1);
        check_eq("wt_hit_data", tx_data[0], 128'h00000000_00000011_00000000_00000000);
        check_eq("wt_hit_lat", lat, 3);

        wb_mode = 1'b1;
        access_a("ev230", 1'b0, 10'h230, 8'h00, 128'h0, 0);
        check_eq("ev230_tx", {n_tx[2:0], tx_rw[0], tx_addr[0]}, {3'd1, 1'b0, 10'h230});
        access_a("ev250", 1'b0, 10'h250, 8'h00, 128'h0, 0);
        check_eq("ev250_clean", {n_tx[2:0], tx_rw[0], tx_addr[0]}, {3'd1, 1'b0, 10'h250});

        @(negedge clk);
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_addr = 10'h3A0;
        @(posedge clk);
        @(negedge clk);
        cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_pre_req", {mem_req, mem_addr}, {1'b1, 10'h3A0});
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_mid_mem", {mem_req, mem_rw, mem_addr}, 12'h0);
        check_eq("rst_mid_wdata", mem_wdata, 128'h0);
        check_eq("rst_mid_cpu", {cpu_ready, cpu_hit, cpu_rdata}, 10'h0);
        @(negedge clk);
        rst_n = 1'b1;
        access_a("rst_after", 1'b0, 10'h088, 8'h00, 128'h0, 0);
        check_eq("rst_after_hit", r_hit, 0);
        check_eq("rst_after_ntx", n_tx, 1);

        for (int i = 0; i < 11; i++) begin
            access_b(b_addr[i], bh, bra, bd);
            check_eq($sformatf("lru_%0d_done", i), bd, 1);
            check_eq($sformatf("lru_%0d_hit", i), bh, b_exp[i]);
            if (i == 5) check_eq("lru_e_refill", bra, 10'h140);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
